// File: rtl/hazard_detection_unit_if.sv
// Pipeline <-> hazard unit bundle: ID/EX/MEM hazard sources in, pipeline control out.
// Optional statistics signals exist only when HAZARD_STATS_EN is defined.
interface hazard_detection_unit_if
`ifdef HAZARD_STATS_EN
    #(parameter int unsigned STAT_WIDTH = 32)
`endif
    ;
    logic [4:0] rs1_id;
    logic [4:0] rs2_id;
    logic       use_rs1_id;
    logic       use_rs2_id;
    logic       is_ecall_id;
    logic       halt_cond_id;
    logic [4:0] rd_ex;
    logic       mem_read_ex;
    logic       reg_write_ex;
    logic [4:0] rd_mem;
    logic       reg_write_mem;
    logic       mispredict_ex;

    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       halt_pending;
    logic       is_halted;
`ifdef HAZARD_STATS_EN
    logic [STAT_WIDTH-1:0] stall_cycles;
    logic [STAT_WIDTH-1:0] flush_count;
`endif

    // Pipeline side: drives hazard sources, consumes control
    modport master (
        output rs1_id, rs2_id, use_rs1_id, use_rs2_id, is_ecall_id, halt_cond_id,
        output rd_ex, mem_read_ex, reg_write_ex, rd_mem, reg_write_mem, mispredict_ex,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, halt_pending, is_halted
`ifdef HAZARD_STATS_EN
        , input stall_cycles, flush_count
`endif
    );

    // Hazard unit side
    modport slave (
        input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, is_ecall_id, halt_cond_id,
        input  rd_ex, mem_read_ex, reg_write_ex, rd_mem, reg_write_mem, mispredict_ex,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, halt_pending, is_halted
`ifdef HAZARD_STATS_EN
        , output stall_cycles, flush_count
`endif
    );
endinterface

// File: rtl/hazard_detection_unit.sv
// Hazard detection unit for the 5-stage RISC-V core: load-use and ECALL-operand
// stalls, mispredict flush, and the halt-drain FSM retiring the halting ECALL.
// Optional macro HAZARD_STATS_EN adds saturating stall/flush statistics counters.
module hazard_detection_unit #(
    parameter int unsigned HALT_DRAIN_CYCLES = 3,
    parameter int unsigned ECALL_REG         = 17
`ifdef HAZARD_STATS_EN
    , parameter int unsigned STAT_WIDTH      = 32
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    hazard_detection_unit_if.slave hif
);
    localparam int unsigned CNT_W = (HALT_DRAIN_CYCLES > 1) ? $clog2(HALT_DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALTED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;
    logic             ecall_stall;
    logic             stall;

    // Hazards forwarding cannot cover: load result in EX, or a7 still in flight for ECALL
    always_comb begin
        load_use    = hif.mem_read_ex && (hif.rd_ex != 5'd0) &&
                      ((hif.use_rs1_id && (hif.rs1_id == hif.rd_ex)) ||
                       (hif.use_rs2_id && (hif.rs2_id == hif.rd_ex)));
        ecall_stall = hif.is_ecall_id &&
                      ((hif.reg_write_ex  && (hif.rd_ex  == 5'(ECALL_REG))) ||
                       (hif.reg_write_mem && (hif.rd_mem == 5'(ECALL_REG))));
        stall       = (load_use || ecall_stall) && (state_q == S_RUN) && !hif.mispredict_ex;
    end

    // Halt-drain next state; halt request on a wrong-path or stalled ECALL is ignored
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                if (hif.halt_cond_id && !ecall_stall && !hif.mispredict_ex) begin
                    state_d = S_DRAIN;
                    cnt_d   = CNT_W'(HALT_DRAIN_CYCLES - 1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = S_HALTED;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HALTED: ;
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // State and drain counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Pipeline control, priority HALTED > mispredict > DRAIN > stall; reset reads as normal flow
    always_comb begin
        hif.pc_write     = 1'b1;
        hif.if_id_write  = 1'b1;
        hif.if_id_flush  = 1'b0;
        hif.id_ex_bubble = 1'b0;
        if (!reset) begin
            if (state_q == S_HALTED) begin
                hif.pc_write     = 1'b0;
                hif.if_id_write  = 1'b0;
                hif.if_id_flush  = 1'b1;
                hif.id_ex_bubble = 1'b1;
            end else if (hif.mispredict_ex && (state_q == S_RUN)) begin
                hif.if_id_flush  = 1'b1;
                hif.id_ex_bubble = 1'b1;
            end else if (state_q == S_DRAIN) begin
                hif.pc_write     = 1'b0;
                hif.if_id_flush  = 1'b1;
            end else if (stall) begin
                hif.pc_write     = 1'b0;
                hif.if_id_write  = 1'b0;
                hif.id_ex_bubble = 1'b1;
            end
        end
    end

    // Status decoded directly from the state flop
    always_comb begin
        hif.halt_pending = (state_q == S_DRAIN);
        hif.is_halted    = (state_q == S_HALTED);
    end

`ifdef HAZARD_STATS_EN
    logic [STAT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
    logic [STAT_WIDTH-1:0] flush_count_q, flush_count_d;

    // Saturating statistics, frozen once halted
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (state_q != S_HALTED) begin
            if (stall && (stall_cycles_q != '1)) begin
                stall_cycles_d = stall_cycles_q + STAT_WIDTH'(1);
            end
            if (hif.mispredict_ex && (state_q == S_RUN) && (flush_count_q != '1)) begin
                flush_count_d = flush_count_q + STAT_WIDTH'(1);
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    // Statistics outputs
    always_comb begin
        hif.stall_cycles = stall_cycles_q;
        hif.flush_count  = flush_count_q;
    end
`endif
endmodule
